// File: rtl/edf_irq_receiver.sv
// edf_irq_receiver: core-side endpoint of the EDF interrupt handshake with pending slot, nesting stack and latency statistic
module edf_irq_receiver #(
  parameter int NrIrqs = 4,
  parameter int MaxNest = 4,
  parameter int LatWidth = 16,
  localparam int IdWidth = $clog2(NrIrqs),
  localparam int DepthWidth = $clog2(MaxNest + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_valid_i,
  input  logic [IdWidth-1:0]    irq_id_i,
  output logic                  irq_ready_o,
  input  logic                  mie_i,
  output logic                  core_irq_o,
  output logic [IdWidth-1:0]    core_irq_id_o,
  input  logic                  core_ack_i,
  input  logic                  core_done_i,
  output logic [DepthWidth-1:0] depth_o,
  output logic [IdWidth-1:0]    active_id_o,
  output logic [LatWidth-1:0]   lat_max_o,
  input  logic                  lat_clr_i,
  output logic                  err_o
);
  logic                  r_pend;
  logic [IdWidth-1:0]    r_pend_id;
  logic [DepthWidth-1:0] r_depth;
  logic [IdWidth-1:0]    r_stack [MaxNest];
  logic [LatWidth-1:0]   r_lat_cnt;
  logic [LatWidth-1:0]   r_lat_max;
  logic                  r_err;
  logic                  w_full;
  logic                  w_cap;
  logic                  w_push;
  logic                  w_pop;
  logic [DepthWidth-1:0] w_wr_idx;
  logic [DepthWidth-1:0] w_depth_nxt;
  logic [LatWidth-1:0]   w_lat_upd;
  logic [IdWidth-1:0]    w_active;

  assign w_full      = r_depth >= DepthWidth'(MaxNest);
  assign irq_ready_o = rst_ni & mie_i & ~r_pend & ~w_full;
  assign w_cap       = irq_valid_i & irq_ready_o;
  assign w_push      = core_ack_i & r_pend;
  assign w_pop       = core_done_i & (r_depth != '0);
  // a same-cycle pop frees the top slot, so the push overwrites it
  assign w_wr_idx    = w_pop ? r_depth - 1'b1 : r_depth;
  assign w_depth_nxt = r_depth + DepthWidth'(w_push) - DepthWidth'(w_pop);
  // a clear coinciding with a claim keeps the fresh sample
  assign w_lat_upd   = (lat_clr_i || r_lat_cnt > r_lat_max) ? r_lat_cnt : r_lat_max;

  assign core_irq_o    = r_pend;
  assign core_irq_id_o = r_pend_id;
  assign depth_o       = r_depth;
  assign active_id_o   = w_active;
  assign lat_max_o     = r_lat_max;
  assign err_o         = r_err;

  // top-of-stack select, 0 when nothing is in service
  always_comb begin
    w_active = '0;
    for (int i = 0; i < MaxNest; i++)
      if (r_depth == DepthWidth'(i + 1)) w_active = r_stack[i];
  end

  // pending slot: filled by the controller handshake, emptied by the hart claim
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend    <= 1'b0;
      r_pend_id <= '0;
    end else if (w_cap) begin
      r_pend    <= 1'b1;
      r_pend_id <= irq_id_i;
    end else if (w_push) begin
      r_pend    <= 1'b0;
    end
  end

  // saturating capture-to-claim counter and sticky maximum
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lat_cnt <= '0;
      r_lat_max <= '0;
    end else begin
      r_lat_cnt <= w_cap ? '0 : (r_pend && r_lat_cnt != '1) ? r_lat_cnt + 1'b1 : r_lat_cnt;
      r_lat_max <= w_push ? w_lat_upd : lat_clr_i ? '0 : r_lat_max;
    end
  end

  // in-service stack with depth count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_depth <= '0;
      for (int i = 0; i < MaxNest; i++) r_stack[i] <= '0;
    end else begin
      r_depth <= w_depth_nxt;
      for (int i = 0; i < MaxNest; i++)
        if (w_push && w_wr_idx == DepthWidth'(i)) r_stack[i] <= r_pend_id;
    end
  end

  // protocol violation pulse: claim with nothing pending or completion with nothing in service
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err <= 1'b0;
    else r_err <= (core_ack_i & ~r_pend) | (core_done_i & (r_depth == '0));
  end
endmodule

// File: tb/tb_edf_irq_receiver.sv
// tb_edf_irq_receiver: directed and random checks of edf_irq_receiver against a queue-based reference model
module tb_edf_irq_receiver;
  localparam int MAXN = 4;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        irq_valid_i;
  logic [1:0]  irq_id_i;
  logic        irq_ready_o;
  logic        mie_i;
  logic        core_irq_o;
  logic [1:0]  core_irq_id_o;
  logic        core_ack_i;
  logic        core_done_i;
  logic [2:0]  depth_o;
  logic [1:0]  active_id_o;
  logic [15:0] lat_max_o;
  logic        lat_clr_i;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  bit m_pend;
  int m_pid;
  int m_stack[$];
  int m_lat;
  int m_latmax;
  bit m_err;

  edf_irq_receiver #(.NrIrqs(4), .MaxNest(MAXN), .LatWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_valid_i(irq_valid_i), .irq_id_i(irq_id_i),
    .irq_ready_o(irq_ready_o), .mie_i(mie_i), .core_irq_o(core_irq_o),
    .core_irq_id_o(core_irq_id_o), .core_ack_i(core_ack_i), .core_done_i(core_done_i),
    .depth_o(depth_o), .active_id_o(active_id_o), .lat_max_o(lat_max_o),
    .lat_clr_i(lat_clr_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0;
    m_pid = 0;
    m_stack.delete();
    m_lat = 0;
    m_latmax = 0;
    m_err = 0;
  endtask

  task automatic tick();
    bit cap, ack, dok;
    int sz;
    #1;
    sz = m_stack.size();
    cap = irq_valid_i && mie_i && !m_pend && sz < MAXN;
    chk("ready", 32'(irq_ready_o), 32'(mie_i && !m_pend && sz < MAXN));
    ack = core_ack_i && m_pend;
    dok = core_done_i && sz > 0;
    if (ack) m_latmax = lat_clr_i ? m_lat : (m_lat > m_latmax ? m_lat : m_latmax);
    else if (lat_clr_i) m_latmax = 0;
    if (dok) void'(m_stack.pop_back());
    if (ack) m_stack.push_back(m_pid);
    m_err = (core_ack_i && !m_pend) || (core_done_i && sz == 0);
    if (cap) m_lat = 0;
    else if (m_pend && m_lat < 65535) m_lat++;
    if (cap) begin
      m_pend = 1;
      m_pid = int'(irq_id_i);
    end else if (ack) m_pend = 0;
    @(posedge clk_i);
    #1;
    chk("core_irq", 32'(core_irq_o), 32'(m_pend));
    if (m_pend) chk("core_irq_id", 32'(core_irq_id_o), m_pid);
    chk("depth", 32'(depth_o), m_stack.size());
    chk("active_id", 32'(active_id_o), m_stack.size() > 0 ? m_stack[$] : 0);
    chk("lat_max", 32'(lat_max_o), m_latmax);
    chk("err", 32'(err_o), 32'(m_err));
  endtask

  task automatic capture(input logic [1:0] id);
    irq_id_i = id;
    irq_valid_i = 1;
    tick();
    irq_valid_i = 0;
  endtask

  task automatic claim(input bit with_done);
    core_ack_i = 1;
    core_done_i = with_done;
    tick();
    core_ack_i = 0;
    core_done_i = 0;
  endtask

  task automatic finish_one();
    core_done_i = 1;
    tick();
    core_done_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    irq_valid_i = 0;
    irq_id_i = 0;
    mie_i = 1;
    core_ack_i = 0;
    core_done_i = 0;
    lat_clr_i = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(irq_ready_o), 0);
    chk("rst_core_irq", 32'(core_irq_o), 0);
    chk("rst_depth", 32'(depth_o), 0);
    chk("rst_err", 32'(err_o), 0);
    rst_ni = 1;

    capture(2);
    chk("basic_irq", 32'(core_irq_o), 1);
    chk("basic_id", 32'(core_irq_id_o), 2);
    chk("basic_ready_low", 32'(irq_ready_o), 0);
    repeat (5) tick();
    claim(0);
    chk("lat5", 32'(lat_max_o), 5);
    chk("lat5_depth", 32'(depth_o), 1);
    chk("lat5_active", 32'(active_id_o), 2);
    chk("lat5_ready", 32'(irq_ready_o), 1);
    finish_one();

    capture(1); claim(0);
    capture(3); claim(0);
    capture(0); claim(0);
    capture(2); claim(0);
    irq_valid_i = 1;
    irq_id_i = 1;
    tick();
    chk("full_depth", 32'(depth_o), 4);
    chk("full_active", 32'(active_id_o), 2);
    chk("full_ready", 32'(irq_ready_o), 0);
    chk("full_no_capture", 32'(core_irq_o), 0);
    irq_valid_i = 0;
    finish_one();
    chk("pop_depth", 32'(depth_o), 3);
    chk("pop_active", 32'(active_id_o), 0);
    chk("pop_ready", 32'(irq_ready_o), 1);
    repeat (3) finish_one();

    capture(1); claim(0);
    capture(3); claim(1);
    chk("sim_depth", 32'(depth_o), 1);
    chk("sim_active", 32'(active_id_o), 3);
    chk("sim_err", 32'(err_o), 0);
    finish_one();
    capture(2); claim(1);
    chk("sim0_depth", 32'(depth_o), 1);
    chk("sim0_err", 32'(err_o), 1);
    tick();
    chk("sim0_err_pulse", 32'(err_o), 0);

    claim(0);
    chk("ack_empty_err", 32'(err_o), 1);
    chk("ack_empty_depth", 32'(depth_o), 1);
    finish_one();
    finish_one();
    chk("done_empty_err", 32'(err_o), 1);
    chk("done_empty_depth", 32'(depth_o), 0);

    mie_i = 0;
    irq_valid_i = 1;
    irq_id_i = 1;
    tick();
    chk("mie_off_ready", 32'(irq_ready_o), 0);
    mie_i = 1;
    tick();
    irq_valid_i = 0;
    mie_i = 0;
    repeat (12) tick();
    chk("mie_drop_held", 32'(core_irq_o), 1);
    mie_i = 1;
    claim(0);
    chk("lat12", 32'(lat_max_o), 12);

    capture(3);
    repeat (9) tick();
    lat_clr_i = 1;
    claim(0);
    chk("clr_vs_update", 32'(lat_max_o), 9);
    tick();
    lat_clr_i = 0;
    chk("clr_alone", 32'(lat_max_o), 0);

    capture(0);
    #2;
    rst_ni = 0;
    #1;
    chk("arst_core_irq", 32'(core_irq_o), 0);
    chk("arst_depth", 32'(depth_o), 0);
    chk("arst_active", 32'(active_id_o), 0);
    chk("arst_ready", 32'(irq_ready_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1;

    repeat (400) begin
      mie_i = ($urandom_range(0, 9) != 0);
      irq_valid_i = ($urandom_range(0, 1) == 1);
      irq_id_i = 2'($urandom_range(0, 3));
      core_ack_i = ($urandom_range(0, 2) == 0);
      core_done_i = ($urandom_range(0, 4) == 0);
      lat_clr_i = ($urandom_range(0, 19) == 0);
      tick();
    end
    irq_valid_i = 0;
    core_ack_i = 0;
    core_done_i = 0;
    lat_clr_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edf_irq_receiver.md
Name: edf_irq_receiver

Overview:
- Core-side endpoint of the EDF interrupt controller's valid/ready interrupt handshake.
- Accepts the controller's arbitration winner (id + valid) and drives the ready acknowledge back to it.
- Holds the accepted id in a single pending slot, presents it to the hart, and tracks nested in-service interrupts on a bounded stack.
- Records the worst-case claim latency as a sticky statistic.

Parameters:
- NrIrqs, 4: number of interrupt lines; must match the controller.
- MaxNest, 4: depth of the in-service stack (maximum nesting level), >=1.
- LatWidth, 16: width of the latency counter and latency statistic.
- IdWidth (localparam), $clog2(NrIrqs): interrupt id width.
- DepthWidth (localparam), $clog2(MaxNest+1): width of the nesting depth count.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- irq_valid_i  in  1  controller has a winning interrupt.
- irq_id_i  in  IdWidth  id of the winning interrupt.
- irq_ready_o  out  1  acknowledge to controller; transfer occurs when valid & ready.
- mie_i  in  1  global interrupt enable from the hart.
- core_irq_o  out  1  interrupt request to hart (pending slot full).
- core_irq_id_o  out  IdWidth  id held in the pending slot.
- core_ack_i  in  1  hart claims the pending interrupt (1-cycle pulse).
- core_done_i  in  1  hart completes the innermost in-service interrupt (1-cycle pulse).
- depth_o  out  DepthWidth  current nesting depth.
- active_id_o  out  IdWidth  id on top of the in-service stack; 0 when depth is 0.
- lat_max_o  out  LatWidth  sticky maximum capture-to-claim latency, in cycles.
- lat_clr_i  in  1  clears lat_max_o.
- err_o  out  1  1-cycle pulse on a protocol violation.

Behaviour:
- Reset (async), all outputs 0:
  - pend_q=0, pend_id_q=0, depth_q=0, stack entries=0, lat_cnt_q=0, lat_max_q=0, err_q=0.
  - irq_ready_o=0 while rst_ni low.
- Ready rule (combinational from registered state): irq_ready_o = mie_i & ~pend_q & (depth_q < MaxNest).
- Capture:
  - On valid & ready at edge N: pend_q=1 and pend_id_q=irq_id_i from cycle N+1; lat_cnt_q=0.
  - Thus core_irq_o rises 1 cycle after the handshake.
- irq_valid_i may drop or the id may change without ready; no capture occurs and no state changes.
- States (pending slot): EMPTY (pend_q=0), HELD (pend_q=1).
  - EMPTY -> HELD on capture.
  - HELD -> EMPTY on core_ack_i.
  - No other transitions.
- While HELD:
  - lat_cnt_q increments each cycle, saturating at 2^LatWidth-1.
  - mie_i deassertion does not cancel the pending slot; core_irq_o stays high.
- core_ack_i while HELD:
  - Push pend_id_q onto the stack; depth_q+1; pend_q=0.
  - lat_max_q = max(lat_max_q, lat_cnt_q) using the pre-edge lat_cnt_q.
- core_ack_i while EMPTY: ignored; err_o pulses 1 cycle later.
- core_done_i with depth_q>0: pop; active_id_o becomes the new top, or 0 if the stack is empty.
- core_done_i with depth_q=0: ignored; err_o pulses.
- Simultaneous core_ack_i (HELD) and core_done_i (depth>0):
  - Pop then push; depth unchanged.
  - Top is replaced by pend_id_q.
- Simultaneous core_ack_i (HELD) and core_done_i (depth=0): push only; err_o pulses for the done.
- Stack full (depth_q=MaxNest): ready stays low, so a push is impossible.
- Same-cycle lat_clr_i and latency update: the update wins (lat_max_q = lat_cnt_q).
- lat_clr_i alone: lat_max_q=0.
- Same-cycle capture and ack cannot occur (ready requires EMPTY).
- Reset mid-operation: all state discarded immediately; an interrupt the controller has already handed over is lost. The controller re-arbitrates after reset.

Test Plan:
- Basic transfer, mie_i=1: irq_valid_i=1, id=2 at cycle 0 -> irq_ready_o=1 at cycle 0; core_irq_o=1, core_irq_id_o=2 at cycle 1; irq_ready_o=0 from cycle 1.
- Latency: capture at cycle 0, core_ack_i at cycle 6 -> lat_max_o=5 at cycle 7, depth_o=1, active_id_o=2, irq_ready_o=1.
- Nesting to full, MaxNest=4: capture+ack ids 1,3,0,2 -> depth_o=4, active_id_o=2, irq_ready_o=0 with valid held high; core_done_i -> depth_o=3, active_id_o=0, irq_ready_o=1.
- Simultaneous ack+done:
  - Setup: depth=1 (id 1), pending id 3; pulse both together -> depth_o=1, active_id_o=3, err_o=0.
  - Repeat with depth=0 -> depth_o=1, err_o pulses once.
- Violations: core_ack_i while EMPTY -> err_o=1 for one cycle, no state change; core_done_i with depth 0 -> same.
- mie_i=0 -> irq_ready_o=0 with valid high; drop mie_i while HELD -> core_irq_o stays 1.
- Reset asserted while HELD with depth 2 -> all outputs 0 asynchronously.
- lat_clr_i in the same cycle as an ack with lat_cnt=9 -> lat_max_o=9.
